// File: rtl/uart_hello_tx.sv
// Fixed-message 8N1 UART transmitter: sends "Hello World!\r\n" on request.
// All outputs are registered and are derived from the next-state values.
module uart_hello_tx #(
    parameter int unsigned CLK_DIV = 434,
    parameter int unsigned MSG_LEN = 14
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [3:0] char_idx
);

    localparam int unsigned TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TMAX = TW'(CLK_DIV - 1);
    localparam logic [3:0] LAST = 4'(MSG_LEN - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [TW-1:0] timer, timer_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [3:0]    idx_n;
    logic          tx_n, busy_n, done_n, tick;
    logic [7:0]    cur_byte;

    function automatic logic [7:0] rom_byte(input logic [3:0] i);
        case (i)
            4'd0:    rom_byte = 8'h48; // H
            4'd1:    rom_byte = 8'h65; // e
            4'd2:    rom_byte = 8'h6C; // l
            4'd3:    rom_byte = 8'h6C; // l
            4'd4:    rom_byte = 8'h6F; // o
            4'd5:    rom_byte = 8'h20; // space
            4'd6:    rom_byte = 8'h57; // W
            4'd7:    rom_byte = 8'h6F; // o
            4'd8:    rom_byte = 8'h72; // r
            4'd9:    rom_byte = 8'h6C; // l
            4'd10:   rom_byte = 8'h64; // d
            4'd11:   rom_byte = 8'h21; // !
            4'd12:   rom_byte = 8'h0D; // CR
            4'd13:   rom_byte = 8'h0A; // LF
            default: rom_byte = 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            timer    <= '0;
            bit_cnt  <= '0;
            char_idx <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            bit_cnt  <= bit_n;
            char_idx <= idx_n;
            tx       <= tx_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        bit_n   = bit_cnt;
        idx_n   = char_idx;
        done_n  = 1'b0;
        tick    = (timer == TMAX);

        if (state != IDLE && !ena) begin
            state_n = IDLE;
            timer_n = '0;
            bit_n   = '0;
            idx_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    timer_n = '0;
                    bit_n   = '0;
                    if (ena && start) state_n = START;
                end
                START: begin
                    timer_n = tick ? '0 : timer + TW'(1);
                    if (tick) begin
                        state_n = DATA;
                        bit_n   = '0;
                    end
                end
                DATA: begin
                    timer_n = tick ? '0 : timer + TW'(1);
                    if (tick) begin
                        if (bit_cnt == 3'd7) state_n = STOP;
                        else                 bit_n   = bit_cnt + 3'd1;
                    end
                end
                STOP: begin
                    timer_n = tick ? '0 : timer + TW'(1);
                    if (tick) begin
                        if (char_idx < LAST) begin
                            idx_n   = char_idx + 4'd1;
                            state_n = START;
                        end else begin
                            idx_n   = '0;
                            done_n  = 1'b1;
                            state_n = IDLE;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end

        // tx is registered, so drive it from the state being entered
        cur_byte = rom_byte(idx_n);
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = cur_byte[bit_n];
            default: tx_n = 1'b1;
        endcase
        busy_n = (state_n != IDLE);
    end

endmodule
